// File: rtl/dezigzag_buffer.sv
// dezigzag_buffer: reorders 8x8 coefficient blocks from JPEG zigzag order to
// raster order through two ping-pong banks, sustaining one coefficient per clock.
//
// bank state | meaning
// EMPTY      | free, may be written
// FILLING    | write side is part-way through a block
// FULL       | complete block waiting for the read side
// DRAINING   | read side is issuing raster addresses 0..63
module dezigzag_buffer #(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_sob,
  output logic          dout_eob
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

  localparam logic [5:0] ZZ2R [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  bank_state_e   bank_q [2];
  bank_state_e   bank_d [2];
  logic          wbank_q, wbank_d;
  logic [5:0]    wcnt_q, wcnt_d;
  logic          rbank_q, rbank_d;
  logic [5:0]    rcnt_q, rcnt_d;

  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_sob_q, rd_sob_d;
  logic          rd_eob_q, rd_eob_d;

  logic [DW-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          dout_sob_q, dout_sob_d;
  logic          dout_eob_q, dout_eob_d;

  logic [DW-1:0] mem_q [128];

  logic wr_en;
  logic out_load;
  logic rd_load;
  logic rd_issue;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q  <= '{EMPTY, EMPTY};
      wbank_q <= 1'b0;
      wcnt_q  <= 6'd0;
      rbank_q <= 1'b0;
      rcnt_q  <= 6'd0;
    end else begin
      bank_q  <= bank_d;
      wbank_q <= wbank_d;
      wcnt_q  <= wcnt_d;
      rbank_q <= rbank_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // output decode: handshakes derived from the bank states
  always_comb begin
    din_ready = (bank_q[wbank_q] == EMPTY) || (bank_q[wbank_q] == FILLING);
    wr_en     = din_valid && din_ready;
    out_load  = !dout_valid_q || dout_ready;
    rd_load   = !rd_valid_q || out_load;
    rd_issue  = rd_load && ((bank_q[rbank_q] == FULL) || (bank_q[rbank_q] == DRAINING));
  end

  // next state; writer and reader never own the same bank, so their updates cannot collide
  always_comb begin
    bank_d  = bank_q;
    wbank_d = wbank_q;
    wcnt_d  = wcnt_q;
    rbank_d = rbank_q;
    rcnt_d  = rcnt_q;
    if (wr_en) begin
      wcnt_d = wcnt_q + 6'd1;
      if (wcnt_q == 6'd63) begin
        bank_d[wbank_q] = FULL;
        wbank_d         = ~wbank_q;
      end else begin
        bank_d[wbank_q] = FILLING;
      end
    end
    if (rd_issue) begin
      rcnt_d = rcnt_q + 6'd1;
      if (rcnt_q == 6'd63) begin
        bank_d[rbank_q] = EMPTY;
        rbank_d         = ~rbank_q;
      end else begin
        bank_d[rbank_q] = DRAINING;
      end
    end
  end

  // read stage feeds the output register; both stall only when the one ahead is full
  always_comb begin
    rd_data_d    = rd_data_q;
    rd_valid_d   = rd_valid_q;
    rd_sob_d     = rd_sob_q;
    rd_eob_d     = rd_eob_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_sob_d   = dout_sob_q;
    dout_eob_d   = dout_eob_q;
    if (rd_load) begin
      rd_valid_d = rd_issue;
      rd_data_d  = mem_q[{rbank_q, rcnt_q}];
      rd_sob_d   = rd_issue && (rcnt_q == 6'd0);
      rd_eob_d   = rd_issue && (rcnt_q == 6'd63);
    end
    if (out_load) begin
      dout_valid_d = rd_valid_q;
      dout_sob_d   = rd_sob_q;
      dout_eob_d   = rd_eob_q;
      if (rd_valid_q) dout_d = rd_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_sob_q     <= 1'b0;
      rd_eob_q     <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_sob_q   <= 1'b0;
      dout_eob_q   <= 1'b0;
    end else begin
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      rd_sob_q     <= rd_sob_d;
      rd_eob_q     <= rd_eob_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_sob_q   <= dout_sob_d;
      dout_eob_q   <= dout_eob_d;
    end
  end

  // bank storage keeps its contents through reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[{wbank_q, ZZ2R[wcnt_q]}] <= din;
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_sob   = dout_sob_q;
  assign dout_eob   = dout_eob_q;

endmodule

// File: tb/tb_dezigzag_buffer.sv
// Self-checking bench for dezigzag_buffer: directed phases with random data and
// handshakes, checked against a zigzag model built by walking the anti-diagonals.
module tb_dezigzag_buffer;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_sob;
  logic          dout_eob;

  always #5 clk = ~clk;

  dezigzag_buffer #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_sob(dout_sob), .dout_eob(dout_eob)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            pos;
  } exp_t;

  exp_t          exp_q[$];
  int            z2r [64];
  int            r2z [64];
  logic [DW-1:0] blk [64];
  logic [DW-1:0] src [64];
  logic [DW-1:0] got [64];
  int            part;
  int            checks = 0;
  int            errors = 0;
  logic          accepted;
  logic          feed_dead;
  logic          prev_stall;
  logic [DW-1:0] prev_dout;
  logic          prev_sob, prev_eob;
  logic          chk_rdy1, chk_stream, seen_out, chk_release;
  int            row0 [8] = '{0, 1, 5, 6, 14, 15, 27, 28};
  int            row1 [8] = '{2, 4, 7, 13, 16, 26, 29, 42};
  int            row7 [8] = '{35, 36, 48, 49, 57, 58, 62, 63};
  logic [DW-1:0] bases [4] = '{12'h000, 12'h100, 12'h200, 12'h3C0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=completion", tag);
  endtask

  // zigzag order: anti-diagonal s, odd diagonals walk down the rows, even ones walk up
  function automatic void build_tables();
    int n, lo, hi;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 1) begin
        for (int row = lo; row <= hi; row++) begin z2r[n] = row * 8 + (s - row); n++; end
      end else begin
        for (int row = hi; row >= lo; row--) begin z2r[n] = row * 8 + (s - row); n++; end
      end
    end
    for (int i = 0; i < 64; i++) r2z[z2r[i]] = i;
  endfunction

  task automatic observe();
    exp_t e;
    accepted = 1'b0;
    if (prev_stall) begin
      chk("hold_valid", 32'(dout_valid), 32'd1);
      chk("hold_data", 32'(dout), 32'(prev_dout));
      chk("hold_sob", 32'(dout_sob), 32'(prev_sob));
      chk("hold_eob", 32'(dout_eob), 32'(prev_eob));
    end
    if (exp_q.size() == 0) chk("idle_valid", 32'(dout_valid), 32'd0);
    if (chk_rdy1) chk("din_ready_high", 32'(din_ready), 32'd1);
    if (chk_stream && seen_out && exp_q.size() > 0) chk("no_bubble", 32'(dout_valid), 32'd1);
    if (chk_stream && dout_valid) seen_out = 1'b1;
    if (dout_valid && dout_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dout_data", 32'(dout), 32'(e.data));
      chk("dout_sob", 32'(dout_sob), 32'(e.pos == 0));
      chk("dout_eob", 32'(dout_eob), 32'(e.pos == 63));
      got[e.pos] = dout;
      if (chk_release) begin
        if (e.pos <= 60) chk("release_din_ready_low", 32'(din_ready), 32'd0);
        if (e.pos >= 62) chk("release_din_ready_high", 32'(din_ready), 32'd1);
        if (e.pos == 63) chk_release = 1'b0;
      end
    end
    prev_stall = dout_valid && !dout_ready;
    prev_dout  = dout;
    prev_sob   = dout_sob;
    prev_eob   = dout_eob;
    if (din_valid && din_ready) begin
      accepted  = 1'b1;
      blk[part] = din;
      part++;
      if (part == 64) begin
        for (int r = 0; r < 64; r++) begin
          e.data = blk[r2z[r]];
          e.pos  = r;
          exp_q.push_back(e);
        end
        part = 0;
      end
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    @(posedge clk);
    #1;
    din_valid  = v;
    din        = d;
    dout_ready = r;
    @(negedge clk);
    observe();
  endtask

  task automatic feed_range(input int lo, input int hi, input int v_pct, input int r_pct);
    int tries;
    for (int i = lo; i < hi; i++) begin
      if (feed_dead) break;
      tries = 0;
      do begin
        step(int'($urandom_range(0, 99)) < v_pct, src[i], int'($urandom_range(0, 99)) < r_pct);
        tries++;
      end while (!accepted && tries < 500);
      if (!accepted) begin
        timeout_fail("feed");
        feed_dead = 1'b1;
      end
    end
  endtask

  task automatic drain(input int r_pct);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || dout_valid) && n < 1000) begin
      step(1'b0, '0, int'($urandom_range(0, 99)) < r_pct);
      n++;
    end
    if (exp_q.size() > 0) timeout_fail("drain");
  endtask

  task automatic rand_src();
    for (int i = 0; i < 64; i++) src[i] = DW'($urandom);
  endtask

  initial begin
    build_tables();
    rst = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    part = 0; prev_stall = 1'b0; feed_dead = 1'b0;
    chk_rdy1 = 1'b0; chk_stream = 1'b0; seen_out = 1'b0; chk_release = 1'b0;
    #1;
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_valid", 32'(dout_valid), 32'd0);
    chk("reset_sob", 32'(dout_sob), 32'd0);
    chk("reset_eob", 32'(dout_eob), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // single block, din = zigzag index
    step(1'b0, '0, 1'b1);
    chk("din_ready_after_reset", 32'(din_ready), 32'd1);
    for (int i = 0; i < 64; i++) src[i] = DW'(i);
    feed_range(0, 64, 100, 100);
    step(1'b0, '0, 1'b1);
    chk("latency_k1", 32'(dout_valid), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("latency_k2", 32'(dout_valid), 32'd0);
    step(1'b0, '0, 1'b1);
    chk("latency_k3", 32'(dout_valid), 32'd1);
    chk("latency_sob", 32'(dout_sob), 32'd1);
    drain(100);
    for (int c = 0; c < 8; c++) begin
      chk("row0", 32'(got[c]), 32'(row0[c]));
      chk("row1", 32'(got[8 + c]), 32'(row1[c]));
      chk("row7", 32'(got[56 + c]), 32'(row7[c]));
    end

    // four blocks back to back
    chk_rdy1 = 1'b1; chk_stream = 1'b1; seen_out = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 64; i++) src[i] = bases[b] + DW'(i);
      feed_range(0, 64, 100, 100);
    end
    chk_rdy1 = 1'b0;
    drain(100);
    chk_stream = 1'b0;

    // downstream stalled while two blocks arrive
    chk_rdy1 = 1'b1;
    rand_src(); feed_range(0, 64, 100, 0);
    rand_src(); feed_range(0, 64, 100, 0);
    chk_rdy1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b0);
      chk("stall_din_ready_low", 32'(din_ready), 32'd0);
    end
    chk_release = 1'b1;
    drain(100);

    // random back-pressure, then sparse input
    for (int b = 0; b < 3; b++) begin rand_src(); feed_range(0, 64, 100, 50); end
    drain(50);
    for (int b = 0; b < 2; b++) begin rand_src(); feed_range(0, 64, 30, 100); end
    drain(100);

    // reset while block 0 drains and block 1 is part-written
    rand_src(); feed_range(0, 64, 100, 0);
    rand_src(); feed_range(0, 20, 100, 0); feed_range(20, 40, 100, 100);
    @(posedge clk);
    #2;
    rst = 1'b0;
    din_valid = 1'b0;
    #1;
    chk("midreset_dout", 32'(dout), 32'd0);
    chk("midreset_valid", 32'(dout_valid), 32'd0);
    chk("midreset_sob", 32'(dout_sob), 32'd0);
    chk("midreset_eob", 32'(dout_eob), 32'd0);
    exp_q.delete();
    part = 0;
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step(1'b0, '0, 1'b1);
    chk("midreset_din_ready", 32'(din_ready), 32'd1);
    rand_src(); feed_range(0, 64, 100, 100);
    drain(100);

    // extreme values pass bit-exact
    rand_src();
    src[0] = 12'h800; src[63] = 12'h7FF; src[1] = 12'hFFF;
    feed_range(0, 64, 100, 100);
    drain(100);
    chk("extreme_r0", 32'(got[0]), 32'h800);
    chk("extreme_r63", 32'(got[63]), 32'h7FF);
    chk("extreme_r1", 32'(got[1]), 32'hFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
